sram_async_ctrl: RTL and testbench
==================================

# sram_async_ctrl

Synchronous-bus controller for an external asynchronous static RAM (or ROM), parametrised in address width, data width, byte lanes and per-phase cycle counts. It sits between the IHU FPGA fabric and the off-chip memory pins. Each request becomes a read or write cycle whose setup, pulse, hold and turnaround phases are cycle-counted, so device timing is met by construction. It also adds byte-lane writes and bus turnaround, which a plain memory port does not provide.

## Interface
- ABITS, 18, SRAM address width
- DBITS, 16, data width; must be a multiple of 8
- T_ASU, 1, address/data setup cycles before nWE falls (min 1)
- T_WP, 2, nWE low cycles (min 1)
- T_WH, 1, address/data hold cycles after nWE rises (min 1)
- T_RD, 2, read access cycles with nOE low before sampling (min 1)
- T_TA, 1, turnaround cycles between a read and a following write (min 0)
- All T_* parameters are at most 255.

- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- req  in  1  request strobe (level)
- we  in  1  1 = write, 0 = read; sampled on accept
- addr  in  ABITS  word address; sampled on accept
- wdata  in  DBITS  write data; sampled on accept
- be  in  DBITS/8  byte enables for writes, active-high; sampled on accept
- busy  out  1  controller not ready to accept
- ack  out  1  one-cycle completion pulse
- rdata  out  DBITS  read data; valid while ack=1, holds until the next read ack
- sram_a  out  ABITS  registered memory address
- sram_dq_o  out  DBITS  data to pins
- sram_dq_oe  out  1  drive enable for the data pins (the top level builds the inout)
- sram_dq_i  in  DBITS  data from pins
- sram_nCS  out  1  chip select, active-low
- sram_nOE  out  1  output enable, active-low
- sram_nWE  out  1  write enable, active-low
- sram_nBE  out  DBITS/8  byte-lane enables, active-low

## Operation
- **Reset** (any cycle, including mid-operation): state returns to IDLE.
  - busy=0, ack=0, rdata=0, sram_a=0, sram_dq_o=0, sram_dq_oe=0.
  - sram_nCS=1, sram_nOE=1, sram_nWE=1, sram_nBE=all 1.
  - A write aborted by reset leaves that location undefined. No retry is attempted.
- **Accept**: on a clk edge with req=1, busy=0 and rst=0. The controller latches we, addr, wdata and be. sram_a is loaded on this edge and held until the next accept.
- **req while busy=1**: ignored, not queued.
- **States**: IDLE, TURN, WSETUP, WPULSE, WHOLD, RACCESS.
  - Write accept: goes to TURN if the previous operation was a read and T_TA>0, otherwise to WSETUP.
  - TURN (T_TA cycles): nCS=1, nOE=1, dq_oe=0. Then WSETUP.
  - WSETUP (T_ASU cycles): nCS=0, dq_oe=1, nBE=~be, nWE=1. Then WPULSE.
  - WPULSE (T_WP cycles): as WSETUP, but nWE=0. Then WHOLD.
  - WHOLD (T_WH cycles): as WSETUP, nWE=1. Then IDLE with ack.
  - Read accept: goes to RACCESS for T_RD cycles with nCS=0, nOE=0, nBE=0, dq_oe=0, nWE=1. On the last RACCESS edge, rdata is loaded from sram_dq_i. Then IDLE with ack.
- **Phase counter**: 8-bit, loaded with (T_x − 1) on phase entry, decremented to 0.
- **IDLE**: nCS=1, nOE=1, nWE=1, nBE=all 1, dq_oe=0.
- **Invariants**:
  - nOE=0 and dq_oe=1 never occur in the same cycle.
  - nWE is never low while sram_a or sram_dq_o changes.
  - nWE is never low in the first or last cycle of nCS low.
- **Read-after-write**: needs no turnaround.
- **Write-after-write, read-after-read**: back-to-back with no gap.

## Timing
- All outputs are registered; no combinational path from inputs to sram_* pins.
- Cycle count from the accept edge:
  - Write: ack is high in cycle (T_TA if after a read) + T_ASU + T_WP + T_WH + 1.
  - Read: ack is high in cycle T_RD + 1.
- busy=1 from the cycle after accept until ack. busy=0 in the ack cycle, so req=1 in the ack cycle is accepted on the next edge.
- ack=1 for exactly one cycle per accepted request.
- Memory access time available to a read: T_RD·Tclk minus pad and board delays. Set T_RD accordingly.

## Test plan
- **Reset values**: assert rst for 3 cycles mid-read with defaults -> next cycle all outputs at reset values; busy=0.
- **Single write**: defaults, write addr=0x00123, wdata=0xBEEF, be=2'b11 -> nWE low exactly 2 cycles; sram_a and sram_dq_o stable from 1 cycle before nWE falls to 1 cycle after it rises; ack in cycle 5; bench SRAM model (with timing checks) holds 0xBEEF, no violations.
- **Read-back**: read 0x00123 -> nOE low 2 cycles, dq_oe=0 throughout, ack in cycle 3 with rdata=0xBEEF.
- **Turnaround**: read then write with req held high -> one cycle with nCS=nOE=1 and dq_oe=0 between them; write ack 6 cycles after its accept.
- **Byte lane**: write 0x12xx with be=2'b10 over 0xBEEF -> sram_nBE=2'b01 during the write; read-back gives 0x12EF.
- **Busy and abort**: second req pulsed while busy -> ignored, no second ack; rst in WPULSE -> nWE=1 next cycle, state IDLE, no ack.

Source files
------------

// File: rtl/sram_async_ctrl_if.sv
// sram_async_ctrl_if: host request bus; master drives req/we/addr/wdata/be, slave returns busy/ack/rdata
interface sram_async_ctrl_if #(
  parameter int ABITS = 18,
  parameter int DBITS = 16
);
  logic req;
  logic we;
  logic [ABITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic [DBITS/8-1:0] be;
  logic busy;
  logic ack;
  logic [DBITS-1:0] rdata;
  modport master (output req, we, addr, wdata, be, input busy, ack, rdata);
  modport slave (input req, we, addr, wdata, be, output busy, ack, rdata);
endinterface

// File: rtl/sram_async_ctrl.sv
// sram_async_ctrl: cycle-counted async SRAM controller; clk/rst, host bus (slave modport), registered sram_a/dq_o/dq_oe/nCS/nOE/nWE/nBE pins, sram_dq_i in
module sram_async_ctrl #(
  parameter int ABITS = 18,
  parameter int DBITS = 16,
  parameter int T_ASU = 1,
  parameter int T_WP  = 2,
  parameter int T_WH  = 1,
  parameter int T_RD  = 2,
  parameter int T_TA  = 1
) (
  input  logic               clk,
  input  logic               rst,
  sram_async_ctrl_if.slave   bus,
  output logic [ABITS-1:0]   sram_a,
  output logic [DBITS-1:0]   sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [DBITS-1:0]   sram_dq_i,
  output logic               sram_nCS,
  output logic               sram_nOE,
  output logic               sram_nWE,
  output logic [DBITS/8-1:0] sram_nBE
);
  localparam int NB = DBITS/8;
  localparam logic [7:0] C_ASU = 8'(T_ASU - 1);
  localparam logic [7:0] C_WP  = 8'(T_WP - 1);
  localparam logic [7:0] C_WH  = 8'(T_WH - 1);
  localparam logic [7:0] C_RD  = 8'(T_RD - 1);
  localparam logic [7:0] C_TA  = 8'(T_TA - 1);
  typedef enum logic [2:0] {IDLE, TURN, WSETUP, WPULSE, WHOLD, RACCESS} state_t;
  state_t r_state, w_next;
  logic [7:0] r_cnt, w_cnt;
  logic r_last_rd, r_busy, r_ack, w_acc, w_done, w_wr;
  logic [NB-1:0] r_be, w_be;
  logic [DBITS-1:0] r_rdata;
  assign bus.busy  = r_busy;
  assign bus.ack   = r_ack;
  assign bus.rdata = r_rdata;
  assign w_acc = bus.req && r_state == IDLE;
  assign w_be  = w_acc ? bus.be : r_be;
  assign w_wr  = w_next inside {WSETUP, WPULSE, WHOLD};
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt - 8'd1;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt = r_cnt;
        if (w_acc && !bus.we) begin
          w_next = RACCESS;
          w_cnt  = C_RD;
        end else if (w_acc && r_last_rd && T_TA > 0) begin
          w_next = TURN;
          w_cnt  = C_TA;
        end else if (w_acc) begin
          w_next = WSETUP;
          w_cnt  = C_ASU;
        end
      end
      TURN: if (r_cnt == 8'd0) begin
        w_next = WSETUP;
        w_cnt  = C_ASU;
      end
      WSETUP: if (r_cnt == 8'd0) begin
        w_next = WPULSE;
        w_cnt  = C_WP;
      end
      WPULSE: if (r_cnt == 8'd0) begin
        w_next = WHOLD;
        w_cnt  = C_WH;
      end
      WHOLD, RACCESS: if (r_cnt == 8'd0) begin
        w_next = IDLE;
        w_done = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_last_rd  <= 1'b0;
      r_be       <= '0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_rdata    <= '0;
      sram_a     <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_nCS   <= 1'b1;
      sram_nOE   <= 1'b1;
      sram_nWE   <= 1'b1;
      sram_nBE   <= '1;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt;
      r_busy     <= w_next != IDLE;
      r_ack      <= w_done;
      sram_nCS   <= !(w_wr || w_next == RACCESS);
      sram_nOE   <= w_next != RACCESS;
      sram_nWE   <= w_next != WPULSE;
      sram_dq_oe <= w_wr;
      sram_nBE   <= w_wr ? ~w_be : (w_next == RACCESS ? '0 : '1);
      if (w_acc) begin
        r_last_rd <= !bus.we;
        sram_a    <= bus.addr;
      end
      if (w_acc && bus.we) begin
        sram_dq_o <= bus.wdata;
        r_be      <= bus.be;
      end
      if (w_done && r_state == RACCESS) r_rdata <= sram_dq_i;
    end
  end
endmodule

// File: tb/tb_sram_async_ctrl.sv
// tb_sram_async_ctrl: directed checks of sram_async_ctrl against a timing-checked SRAM model
module tb_sram_async_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sram_async_ctrl_if #(.ABITS(18), .DBITS(16)) bus ();
  logic [17:0] sram_a;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic sram_dq_oe, sram_nCS, sram_nOE, sram_nWE;
  logic [1:0] sram_nBE;
  sram_async_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_nCS(sram_nCS), .sram_nOE(sram_nOE), .sram_nWE(sram_nWE), .sram_nBE(sram_nBE)
  );
  logic [15:0] mem [0:1023];
  assign sram_dq_i = (!sram_nCS && !sram_nOE) ? mem[sram_a[9:0]] : 16'h0;
  int n_chk = 0, n_fail = 0;
  int viol = 0, nwe_lo = 0, noe_lo = 0, dq_cnt = 0;
  logic [1:0] wr_nbe = '1, rd_nbe = '1;
  logic p_ncs = 1'b1, p_nwe = 1'b1;
  logic [17:0] p_a = '0;
  logic [15:0] p_dq = '0;
  always @(negedge clk) begin
    if (!sram_nWE && p_ncs) viol++;
    if (sram_nCS && !p_ncs && !p_nwe) viol++;
    if ((!sram_nWE || !p_nwe) && (sram_a != p_a || sram_dq_o != p_dq)) viol++;
    if (!sram_nOE && sram_dq_oe) viol++;
    if (!sram_nCS && sram_nWE && !p_nwe)
      for (int i = 0; i < 2; i++)
        if (!sram_nBE[i]) mem[sram_a[9:0]][8*i +: 8] = sram_dq_o[8*i +: 8];
    if (!sram_nWE) nwe_lo++;
    if (!sram_nOE) begin
      noe_lo++;
      rd_nbe = sram_nBE;
    end
    if (sram_dq_oe) begin
      dq_cnt++;
      wr_nbe = sram_nBE;
    end
    p_ncs = sram_nCS;
    p_nwe = sram_nWE;
    p_a   = sram_a;
    p_dq  = sram_dq_o;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clear_stats();
    nwe_lo = 0;
    noe_lo = 0;
    dq_cnt = 0;
    wr_nbe = '1;
    rd_nbe = '1;
  endtask
  task automatic wait_ack(input int s, output int n);
    n = s;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack && n < 60);
    if (!bus.ack) n = -1;
  endtask
  task automatic op(input logic w, input logic [17:0] a, input logic [15:0] d, input logic [1:0] b, output int n);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = b;
    @(posedge clk);
    #1 bus.req = 1'b0;
    clear_stats();
    wait_ack(0, n);
  endtask
  initial begin
    int n, acks;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 18'h5;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_a", 32'(sram_a), 32'd0);
    check("rst_dq_o", 32'(sram_dq_o), 32'd0);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_ncs", 32'(sram_nCS), 32'd1);
    check("rst_noe", 32'(sram_nOE), 32'd1);
    check("rst_nwe", 32'(sram_nWE), 32'd1);
    check("rst_nbe", 32'(sram_nBE), 32'd3);
    op(1'b1, 18'h00123, 16'hBEEF, 2'b11, n);
    check("wr_ack_cycle", n, 5);
    check("wr_nwe_low", nwe_lo, 2);
    check("wr_dq_oe_cycles", dq_cnt, 4);
    check("wr_nbe", 32'(wr_nbe), 32'd0);
    check("wr_mem", 32'(mem[10'h123]), 32'hBEEF);
    op(1'b0, 18'h00123, 16'h0, 2'b00, n);
    check("rd_ack_cycle", n, 3);
    check("rd_noe_low", noe_lo, 2);
    check("rd_dq_oe_cycles", dq_cnt, 0);
    check("rd_nbe", 32'(rd_nbe), 32'd0);
    check("rd_data", 32'(bus.rdata), 32'hBEEF);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 18'h00123;
    @(posedge clk);
    #1 clear_stats();
    wait_ack(0, n);
    check("ta_rd_ack_cycle", n, 3);
    bus.we = 1'b1; bus.addr = 18'h00200; bus.wdata = 16'h5A5A; bus.be = 2'b11;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    check("ta_ncs", 32'(sram_nCS), 32'd1);
    check("ta_noe", 32'(sram_nOE), 32'd1);
    check("ta_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("ta_busy", 32'(bus.busy), 32'd1);
    wait_ack(1, n);
    check("ta_wr_ack_cycle", n, 6);
    check("ta_mem", 32'(mem[10'h200]), 32'h5A5A);
    op(1'b1, 18'h00123, 16'h1234, 2'b10, n);
    check("bl_ack_cycle", n, 5);
    check("bl_nbe", 32'(wr_nbe), 32'd1);
    op(1'b0, 18'h00123, 16'h0, 2'b00, n);
    check("bl_rd_ack_cycle", n, 3);
    check("bl_rdata", 32'(bus.rdata), 32'h12EF);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 18'h00300; bus.wdata = 16'h1111; bus.be = 2'b11;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 18'h00123;
    @(posedge clk);
    #1 bus.req = 1'b0;
    wait_ack(1, n);
    check("busy_wr_ack_cycle", n, 6);
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.ack) acks++;
    end
    check("busy_extra_acks", acks, 0);
    check("busy_mem", 32'(mem[10'h300]), 32'h1111);
    check("timing_violations", viol, 0);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 18'h00301; bus.wdata = 16'h2222; bus.be = 2'b11;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ab_in_pulse", 32'(sram_nWE), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ab_nwe", 32'(sram_nWE), 32'd1);
    check("ab_ncs", 32'(sram_nCS), 32'd1);
    check("ab_busy", 32'(bus.busy), 32'd0);
    acks = int'(bus.ack);
    repeat (8) begin
      @(negedge clk);
      if (bus.ack) acks++;
    end
    check("ab_no_ack", acks, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
